// File: rtl/corr_pair_scheduler.sv
// Walks every antenna pair (i<=j) of one snapshot through the correlator and
// stores each accumulated result in the covariance memory at its pair index.
//
// state    | meaning
// S_IDLE   | waiting for i_start
// S_STREAM | reading samples of pair (i,j) and streaming x/y beats
// S_WAIT   | last beat sent, waiting for the correlator result
// S_WRITE  | one-cycle write of the latched result, then next pair or done
// S_DONE   | one-cycle done pulse
// S_ERR    | one-cycle error pulse after result timeout
module corr_pair_scheduler #(
   parameter int DATA_WIDTH_BITS = 12,
   parameter int NUM_ANT         = 4,
   parameter int SNAP_LEN        = 256,
   parameter int ADDR_W          = 8,
   parameter int TIMEOUT         = 64,
   localparam int P      = NUM_ANT * (NUM_ANT + 1) / 2,
   localparam int ANT_W  = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1,
   localparam int PAIR_W = (P > 1) ? $clog2(P) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_start,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_error,
   output logic                       o_rd_en,
   output logic [ADDR_W-1:0]          o_rd_addr,
   output logic [ANT_W-1:0]           o_rd_ant_x,
   output logic [ANT_W-1:0]           o_rd_ant_y,
   input  logic [DATA_WIDTH_BITS-1:0] i_rd_x_r,
   input  logic [DATA_WIDTH_BITS-1:0] i_rd_x_c,
   input  logic [DATA_WIDTH_BITS-1:0] i_rd_y_r,
   input  logic [DATA_WIDTH_BITS-1:0] i_rd_y_c,
   output logic [DATA_WIDTH_BITS-1:0] o_x_r,
   output logic [DATA_WIDTH_BITS-1:0] o_x_c,
   output logic [DATA_WIDTH_BITS-1:0] o_y_r,
   output logic [DATA_WIDTH_BITS-1:0] o_y_c,
   output logic                       o_x_valid,
   output logic                       o_y_valid,
   output logic                       o_x_last,
   output logic                       o_y_last,
   input  logic                       i_ready_x,
   input  logic                       i_ready_y,
   input  logic                       i_res_valid,
   input  logic [30:0]                i_res_r,
   input  logic [30:0]                i_res_c,
   output logic                       o_wr_en,
   output logic [PAIR_W-1:0]          o_wr_addr,
   output logic [30:0]                o_wr_r,
   output logic [30:0]                o_wr_c
);

   localparam int DW    = DATA_WIDTH_BITS;
   localparam int BW    = 4 * DW + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [ANT_W-1:0]  ANT_LAST  = ANT_W'(NUM_ANT - 1);
   localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(P - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SNAP_LEN - 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT, S_WRITE, S_DONE, S_ERR} state_t;

   state_t              r_state, w_state_nxt;
   logic [PAIR_W-1:0]   r_pair;
   logic [ANT_W-1:0]    r_ant_i, r_ant_j;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_rd_all;
   logic                r_pend, r_pend_last;
   logic                r_out_valid, r_skid_valid;
   logic [BW-1:0]       r_out_beat, r_skid_beat;
   logic [TMR_W-1:0]    r_tmr;
   logic [30:0]         r_wr_r, r_wr_c;
   logic                w_xfer, w_last_xfer, w_rd_en;
   logic [BW-1:0]       w_rd_beat;

   assign w_xfer      = r_out_valid & i_ready_x & i_ready_y;
   assign w_last_xfer = w_xfer & r_out_beat[0];
   assign w_rd_beat   = {i_rd_x_r, i_rd_x_c, i_rd_y_r, i_rd_y_c, r_pend_last};
   // A read in flight landing on a stalled output goes to the skid, so hold off
   // a new read whenever that would leave no room for it.
   assign w_rd_en = (r_state == S_STREAM) & ~r_rd_all & ~r_skid_valid &
                    ~(r_out_valid & r_pend & ~w_xfer);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_pair       <= '0;
         r_ant_i      <= '0;
         r_ant_j      <= '0;
         r_rd_addr    <= '0;
         r_rd_all     <= 1'b0;
         r_pend       <= 1'b0;
         r_pend_last  <= 1'b0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_beat   <= '0;
         r_skid_beat  <= '0;
         r_tmr        <= '0;
         r_wr_r       <= '0;
         r_wr_c       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_rd_en;
         if (w_rd_en) begin
            r_pend_last <= (r_rd_addr == ADDR_LAST);
            if (r_rd_addr == ADDR_LAST) r_rd_all  <= 1'b1;
            else                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
         end
         if (w_xfer || !r_out_valid) begin
            if (r_skid_valid) begin
               r_out_beat   <= r_skid_beat;
               r_out_valid  <= 1'b1;
               r_skid_valid <= r_pend;
               if (r_pend) r_skid_beat <= w_rd_beat;
            end else begin
               r_out_valid <= r_pend;
               if (r_pend) r_out_beat <= w_rd_beat;
            end
         end else if (r_pend) begin
            r_skid_beat  <= w_rd_beat;
            r_skid_valid <= 1'b1;
         end
         if (w_last_xfer) r_tmr <= TMR_LOAD;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_pair    <= '0;
               r_ant_i   <= '0;
               r_ant_j   <= '0;
               r_rd_addr <= '0;
               r_rd_all  <= 1'b0;
            end
            S_WAIT: begin
               r_tmr <= r_tmr - TMR_W'(1);
               if (i_res_valid) begin
                  r_wr_r <= i_res_r;
                  r_wr_c <= i_res_c;
               end
            end
            S_WRITE: if (r_pair != PAIR_LAST) begin
               r_pair    <= r_pair + PAIR_W'(1);
               r_rd_addr <= '0;
               r_rd_all  <= 1'b0;
               if (r_ant_j == ANT_LAST) begin
                  r_ant_i <= r_ant_i + ANT_W'(1);
                  r_ant_j <= r_ant_i + ANT_W'(1);
               end else begin
                  r_ant_j <= r_ant_j + ANT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_state_nxt = S_STREAM;
         S_STREAM: if (w_last_xfer) w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_res_valid)                   w_state_nxt = S_WRITE;
            else if (r_tmr == TMR_W'(1))       w_state_nxt = S_ERR;
         end
         S_WRITE:  w_state_nxt = (r_pair == PAIR_LAST) ? S_DONE : S_STREAM;
         S_DONE:   w_state_nxt = S_IDLE;
         S_ERR:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy  = 1'b0;
      o_done  = 1'b0;
      o_error = 1'b0;
      o_wr_en = 1'b0;
      case (r_state)
         S_STREAM, S_WAIT: o_busy = 1'b1;
         S_WRITE: begin
            o_busy  = 1'b1;
            o_wr_en = 1'b1;
         end
         S_DONE:  o_done  = 1'b1;
         S_ERR:   o_error = 1'b1;
         default: ;
      endcase
   end

   assign o_rd_en    = w_rd_en;
   assign o_rd_addr  = r_rd_addr;
   assign o_rd_ant_x = r_ant_i;
   assign o_rd_ant_y = r_ant_j;
   assign o_x_r      = r_out_beat[4*DW:3*DW+1];
   assign o_x_c      = r_out_beat[3*DW:2*DW+1];
   assign o_y_r      = r_out_beat[2*DW:DW+1];
   assign o_y_c      = r_out_beat[DW:1];
   assign o_x_valid  = r_out_valid;
   assign o_y_valid  = r_out_valid;
   assign o_x_last   = r_out_valid & r_out_beat[0];
   assign o_y_last   = r_out_valid & r_out_beat[0];
   assign o_wr_addr  = r_pair;
   assign o_wr_r     = r_wr_r;
   assign o_wr_c     = r_wr_c;

endmodule
